// File: rtl/gemm_pkg.sv
// Shared GEMM geometry and the activation-map reader FSM encoding.
package gemm_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int PE_SIZE         = 14;
  localparam int OUT_CH          = 64;
  localparam int MEM2_DEPTH      = PE_SIZE * OUT_CH;
  localparam int MEM2_DATA_WIDTH = PE_SIZE * DATA_WIDTH;
  localparam int MEM2_ADDR_WIDTH = $clog2(MEM2_DEPTH);
  localparam int MEM2_LEN_WIDTH  = MEM2_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // BRAM2 is not a power of two deep, so the read pointer wraps explicitly.
  function automatic logic [MEM2_ADDR_WIDTH-1:0] mem2_addr_inc(
    input logic [MEM2_ADDR_WIDTH-1:0] addr
  );
    if (addr == MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1)) begin
      return '0;
    end
    return addr + 1'b1;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready FIFO; accepts a push while full if the head pops in the same cycle.
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_pop, do_push;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    rd_ptr_d = rd_ptr_q ^ do_pop;
    wr_ptr_d = wr_ptr_q ^ do_push;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (do_push && (wr_ptr_q == 1'(gi))) begin
        entry_d = push_data_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;
  assign count_o = count_q;

endmodule

// File: rtl/act_map_reader.sv
// Drains a window of BRAM2 through read port 1 into a valid/ready stream with a last marker.
module act_map_reader
  import gemm_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [MEM2_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [MEM2_LEN_WIDTH-1:0]  len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1_o,
  output logic                       mem2_ce1_o,
  output logic                       mem2_we1_o,
  output logic [MEM2_DATA_WIDTH-1:0] mem2_d1_o,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
  output logic                       m_last_o
);

  state_e                     state_q, state_d;
  logic [MEM2_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM2_LEN_WIDTH-1:0]  len_q, len_d;
  logic [MEM2_LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                       inflight_q, inflight_d;
  logic                       inflight_last_q, inflight_last_d;

  logic                       ce1;
  logic                       pop;
  logic [1:0]                 fifo_count;
  logic [2:0]                 occupancy;
  logic                       fifo_last;
  logic [MEM2_DATA_WIDTH-1:0] fifo_data;

  assign pop = m_valid_o & m_ready_i;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    inflight_last_d = 1'b0;
    ce1             = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    // Words held after this edge: buffered plus in flight, minus the one leaving now.
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          // Zero-length drains pass through DRAIN so done_o still lands two cycles after start.
          state_d  = (len_i == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        busy_o = 1'b1;
        if ((issued_q < len_q) && (occupancy < 3'd2)) begin
          ce1             = 1'b1;
          addr_d          = mem2_addr_inc(addr_q);
          issued_d        = issued_q + 1'b1;
          inflight_last_d = (issued_q == len_q - 1'b1);
        end
        if (issued_d == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (occupancy == 3'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    inflight_d = ce1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  skid_fifo2 #(
    .WIDTH(MEM2_DATA_WIDTH + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, mem2_q1_i}),
    .pop_i       (pop),
    .valid_o     (m_valid_o),
    .data_o      ({fifo_last, fifo_data}),
    .count_o     (fifo_count)
  );

  assign m_data_o     = fifo_data;
  assign m_last_o     = fifo_last & m_valid_o;
  assign mem2_addr1_o = addr_q;
  assign mem2_ce1_o   = ce1;
  assign mem2_we1_o   = 1'b0;
  assign mem2_d1_o    = '0;

endmodule

// File: tb/tb_act_map_reader.sv
// Randomized bench for act_map_reader: BRAM2 model, expected-word queue and cycle-level checks.
module tb_act_map_reader;
  import gemm_pkg::*;

  localparam int AW    = MEM2_ADDR_WIDTH;
  localparam int DW    = MEM2_DATA_WIDTH;
  localparam int LW    = MEM2_LEN_WIDTH;
  localparam int DEPTH = MEM2_DEPTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o;
  logic [AW-1:0] mem2_addr1_o;
  logic          mem2_ce1_o, mem2_we1_o;
  logic [DW-1:0] mem2_d1_o;
  logic [DW-1:0] mem2_q1_i;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;

  always #5 clk = ~clk;

  act_map_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem2_addr1_o (mem2_addr1_o),
    .mem2_ce1_o   (mem2_ce1_o),
    .mem2_we1_o   (mem2_we1_o),
    .mem2_d1_o    (mem2_d1_o),
    .mem2_q1_i    (mem2_q1_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o)
  );

  // BRAM2 port 1: one-cycle registered read; junk when not enabled.
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem2_ce1_o) mem2_q1_i <= bram[mem2_addr1_o];
    else            mem2_q1_i <= DW'({$urandom, $urandom, $urandom, $urandom});
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state for the drain under test.
  bit            m_active = 1'b0;
  int            m_base, m_c0, m_nreads, m_nhs;
  int            first_ce, first_v, last_hs, done_cyc, n_done;
  logic [DW:0]   exp_q[$];
  bit            prev_stall;
  logic [DW:0]   prev_word;

  always @(negedge clk) begin
    if (m_active && rst_n) begin
      int          held;
      bit          pop;
      logic [DW:0] w;
      pop  = m_valid_o && m_ready_i;
      held = m_nreads - m_nhs;
      if (prev_stall)
        chk("stall_hold", 128'({m_valid_o, m_last_o, m_data_o}), 128'({1'b1, prev_word}));
      if (mem2_ce1_o) begin
        if (first_ce < 0) first_ce = cyc;
        chk("rd_addr", 128'(mem2_addr1_o), 128'((m_base + m_nreads) % DEPTH));
        chk("occupancy", 128'((held - int'(pop)) < 2), 128'(1));
        m_nreads++;
      end
      if (m_valid_o && first_v < 0) first_v = cyc;
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 128'(1), 128'(0));
        end else begin
          w = exp_q.pop_front();
          chk("beat", 128'({m_last_o, m_data_o}), 128'(w));
        end
        m_nhs++;
        last_hs = cyc;
      end
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_at_done", 128'(busy_o), 128'(0));
      end else if (cyc > m_c0 && done_cyc < 0) begin
        chk("busy", 128'(busy_o), 128'(1));
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_word  = {m_last_o, m_data_o};
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  128'(busy_o),       128'(0));
    chk({tag, "_done"},  128'(done_o),       128'(0));
    chk({tag, "_valid"}, 128'(m_valid_o),    128'(0));
    chk({tag, "_last"},  128'(m_last_o),     128'(0));
    chk({tag, "_data"},  128'(m_data_o),     128'(0));
    chk({tag, "_ce1"},   128'(mem2_ce1_o),   128'(0));
    chk({tag, "_addr"},  128'(mem2_addr1_o), 128'(0));
  endtask

  task automatic run_drain(input int base, input int len, input int ready_pct, input bit poke_start);
    int c0;
    int budget;
    exp_q.delete();
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), bram[(base + i) % DEPTH]});
    m_base = base; m_nreads = 0; m_nhs = 0;
    first_ce = -1; first_v = -1; last_hs = -1; done_cyc = -1; n_done = 0;
    prev_stall = 1'b0;

    @(posedge clk); #1;
    c0 = cyc; m_c0 = c0; m_active = 1'b1;
    start_i = 1'b1; base_addr_i = AW'(base); len_i = LW'(len);
    m_ready_i = ($urandom_range(99) < ready_pct);
    budget = 8 * len + 40;
    while (done_cyc < 0 && budget > 0) begin
      @(posedge clk); #1;
      start_i = poke_start && (cyc == c0 + 6);
      if (start_i) begin
        base_addr_i = AW'(5);
        len_i       = LW'(3);
      end
      m_ready_i = ($urandom_range(99) < ready_pct);
      budget--;
    end
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      m_ready_i = ($urandom_range(99) < ready_pct);
    end
    m_active = 1'b0;

    chk("done_seen", 128'(done_cyc >= 0), 128'(1));
    chk("done_pulses", 128'(n_done), 128'(1));
    chk("beat_count", 128'(m_nhs), 128'(len));
    chk("leftover", 128'(exp_q.size()), 128'(0));
    chk("post_busy", 128'(busy_o), 128'(0));
    chk("post_valid", 128'(m_valid_o), 128'(0));
    if (len > 0) begin
      chk("first_ce_lat", 128'(first_ce - c0), 128'(1));
      chk("first_valid_lat", 128'(first_v - c0), 128'(3));
      chk("done_after_last", 128'(done_cyc - last_hs), 128'(1));
    end else begin
      chk("len0_no_ce", 128'(m_nreads), 128'(0));
      chk("len0_no_valid", 128'(first_v), 128'(-1));
      chk("len0_done_lat", 128'(done_cyc - c0), 128'(2));
    end
    $display("drain base=%0d len=%0d ready=%0d%% beats=%0d reads=%0d done_cyc=%0d",
             base, len, ready_pct, m_nhs, m_nreads, done_cyc - c0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      bram[i] = DW'({$urandom, $urandom, $urandom, $urandom});

    #1;
    check_idle_outputs("reset");
    chk("reset_we1", 128'(mem2_we1_o), 128'(0));
    chk("reset_d1", 128'(mem2_d1_o), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_drain(0, DEPTH, 100, 1'b0);
    run_drain(100, 200, 50, 1'b0);
    run_drain(890, 10, 60, 1'b0);
    run_drain(321, 1, 100, 1'b0);
    run_drain(17, 0, 100, 1'b0);
    run_drain(50, 20, 50, 1'b1);

    // Abort a stalled drain with the FIFO full, then verify a clean restart.
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = AW'(0); len_i = LW'(100); m_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_valid", 128'(m_valid_o), 128'(1));
    chk("pre_abort_busy", 128'(busy_o), 128'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("abort_hold");
    rst_n = 1'b1;
    $display("abort reset applied mid-drain base=0 len=100");

    run_drain(7, 4, 50, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
